// File: rtl/input_buffer_if.sv
// Link-side and route-computation-side signals of one router input buffer.
// The master modport drives writes and consumes flits; the slave is the buffer.
interface input_buffer_if #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 3,
  parameter int DATASIZE = 40
);
  logic [DATASIZE-1:0] data_in;
  logic                valid_in;
  logic                ready_out;
  logic [DATASIZE-1:0] data_out;
  logic                valid_out;
  logic                rc_ready;
  logic [WIDTH:0]      pressure_out;
  logic                overflow_err;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  data_out,
    input  valid_out,
    output rc_ready,
    input  pressure_out,
    input  overflow_err
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output data_out,
    output valid_out,
    input  rc_ready,
    output pressure_out,
    output overflow_err
  );
endinterface

// File: rtl/input_buffer.sv
// Show-ahead circular flit FIFO with occupancy output and sticky overflow.
// Storage is not reset; only pointers, count and the overflow flag are.
module input_buffer #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 3,
  parameter int DATASIZE = 40
) (
  input logic           ib_clk,
  input logic           rst,
  input_buffer_if.slave bus
);

  localparam logic [WIDTH:0]   LP_FULL = (WIDTH+1)'(DEPTH);
  localparam logic [WIDTH:0]   LP_ZERO = '0;
  localparam logic [WIDTH:0]   LP_CONE = 1;
  localparam logic [WIDTH-1:0] LP_PONE = 1;

  logic [DATASIZE-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0]    r_wr_ptr;
  logic [WIDTH-1:0]    r_rd_ptr;
  logic [WIDTH:0]      r_count;
  logic                r_ovf;

  logic w_ready;
  logic w_valid;
  logic w_push;
  logic w_pop;

  assign w_ready = (r_count != LP_FULL);
  assign w_valid = (r_count != LP_ZERO);
  assign w_push  = bus.valid_in && w_ready;
  assign w_pop   = w_valid && bus.rc_ready;

  assign bus.ready_out    = w_ready;
  assign bus.valid_out    = w_valid;
  assign bus.data_out     = r_mem[r_rd_ptr];
  assign bus.pressure_out = r_count;
  assign bus.overflow_err = r_ovf;

  // rst gate keeps an edge during reset from writing a stale entry
  always_ff @(posedge ib_clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge ib_clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LP_PONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LP_PONE;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CONE;
        2'b01:   r_count <= r_count - LP_CONE;
        default: r_count <= r_count;
      endcase
      if (bus.valid_in && !w_ready) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_input_buffer.sv
// Random and directed stimulus for input_buffer against a queue model.
// The model tracks stored flits, occupancy and the sticky overflow flag.
module tb_input_buffer;

  localparam int DEPTH = 8;
  localparam int WIDTH = 3;
  localparam int DW    = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  input_buffer_if #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .DATASIZE(DW)
  ) bus ();

  input_buffer #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .DATASIZE(DW)
  ) dut (
    .ib_clk(clk),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf = 1'b0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ":valid"}, 64'(bus.valid_out), 64'(q.size() != 0));
    check({tag, ":ready"}, 64'(bus.ready_out), 64'(q.size() != DEPTH));
    check({tag, ":press"}, 64'(bus.pressure_out), 64'(q.size()));
    check({tag, ":ovf"}, 64'(bus.overflow_err), 64'(m_ovf));
    if (q.size() != 0) begin
      check({tag, ":data"}, 64'(bus.data_out), 64'(q[0]));
    end
  endtask

  // Inputs are applied 1 time unit after an edge and checked 1 after the next.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit r,
                     input string tag);
    bit full;
    bit emp;
    bus.valid_in = v;
    bus.data_in  = d;
    bus.rc_ready = r;
    @(posedge clk);
    full = (q.size() == DEPTH);
    emp  = (q.size() == 0);
    if (!rst) begin
      if (r && !emp) void'(q.pop_front());
      if (v && !full) q.push_back(d);
      if (v && full) m_ovf = 1'b1;
    end
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    m_ovf = 1'b0;
    check_all({tag, ":async"});
    bus.valid_in = 1'b1;
    bus.rc_ready = 1'b1;
    @(posedge clk);
    #1;
    check_all({tag, ":held"});
    @(negedge clk);
    rst = 1'b0;
    bus.valid_in = 1'b0;
    bus.rc_ready = 1'b0;
    @(posedge clk);
    #1;
    check_all({tag, ":post"});
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom(), $urandom()});
  endfunction

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus.rc_ready = 1'b0;
    #3;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b1, DW'(i), 1'b0, "fill");
    end
    check("full_ready", 64'(bus.ready_out), 64'd0);

    cyc(1'b1, DW'(8'hFF), 1'b0, "ovf");
    check("ovf_set", 64'(bus.overflow_err), 64'd1);
    cyc(1'b0, '0, 1'b0, "ovf_idle");

    for (int i = 1; i <= DEPTH; i++) begin
      check("drain_order", 64'(bus.data_out), 64'(i));
      cyc(1'b0, '0, 1'b1, "drain");
    end
    check("drain_empty", 64'(bus.valid_out), 64'd0);
    cyc(1'b0, '0, 1'b1, "pop_empty");
    check("ovf_sticky", 64'(bus.overflow_err), 64'd1);

    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, rnd(), 1'b0, "pre4");
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, rnd(), 1'b1, "simul");
      check("simul_press", 64'(bus.pressure_out), 64'd4);
    end

    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, rnd(), 1'b0, "to_full");
    end
    cyc(1'b1, rnd(), 1'b1, "full_pop");
    check("full_pop_cnt", 64'(bus.pressure_out), 64'd7);
    cyc(1'b1, rnd(), 1'b0, "refill");
    check("refill_cnt", 64'(bus.pressure_out), 64'd8);

    async_reset("rst_full");
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, rnd(), 1'b0, "pre5");
    end
    async_reset("rst_mid");
    cyc(1'b1, DW'(8'hA5), 1'b0, "a5");
    check("a5_data", 64'(bus.data_out), 64'hA5);
    check("a5_press", 64'(bus.pressure_out), 64'd1);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) < 60), rnd(),
          ($urandom_range(0, 99) < 45), "rand");
      if (i == 200) async_reset("rst_rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/input_buffer.md
INPUT_BUFFER -- requirements
Module: input_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two).
REQ-002 The block SHALL have parameter WIDTH, default 3, meaning log2(DEPTH), the pointer width.
REQ-003 The block SHALL have parameter DATASIZE, default 40, meaning flit width in bits.
REQ-004 The block SHALL have port ib_clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 The block SHALL have port data_in  input  DATASIZE  flit from upstream link.
REQ-007 The block SHALL have port valid_in  input  1  upstream write request.
REQ-008 The block SHALL have port ready_out  output  1  buffer can accept a flit this cycle.
REQ-009 The block SHALL have port data_out  output  DATASIZE  head flit presented to route computation.
REQ-010 The block SHALL have port valid_out  output  1  head flit valid; drives the route-computation valid_in.
REQ-011 The block SHALL have port rc_ready  input  1  route computation consumes the head flit.
REQ-012 The block SHALL have port pressure_out  output  WIDTH+1  current occupancy; drives neighbour *_pressure_in.
REQ-013 The block SHALL have port overflow_err  output  1  sticky flag: write attempted while full.

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH x DATASIZE, with wr_ptr and rd_ptr of WIDTH bits and count of WIDTH+1 bits.
REQ-015 ready_out SHALL equal (count != DEPTH), combinational from registered count.
REQ-016 valid_out SHALL equal (count != 0); data_out SHALL equal mem[rd_ptr] (show-ahead, no read latency).
REQ-017 Push SHALL occur on a clock edge when valid_in && ready_out: mem[wr_ptr] <= data_in, wr_ptr increments.
REQ-018 Pop SHALL occur on a clock edge when valid_out && rc_ready: rd_ptr increments; rc_ready while empty SHALL have no effect.
REQ-019 Pointers SHALL wrap from DEPTH-1 to 0 by natural WIDTH-bit overflow.
REQ-020 count SHALL update as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-021 Simultaneous push and pop when full SHALL be impossible (ready_out=0); only the pop occurs, and count goes to DEPTH-1.
REQ-022 Push into an empty buffer SHALL be visible as valid_out=1 with data_out=data_in one cycle after the write edge (1-cycle latency); no same-cycle bypass.
REQ-023 valid_in while full SHALL drop the flit, leave all pointers and count unchanged, and set overflow_err=1 on that edge.
REQ-024 overflow_err SHALL remain 1 until rst.
REQ-025 pressure_out SHALL equal count, range 0..DEPTH, updated on the same edge as count.
REQ-026 data_out SHALL hold stable while valid_out=1 and no pop occurs.

Reset
REQ-027 While rst=1, independent of ib_clk: wr_ptr=0, rd_ptr=0, count=0, overflow_err=0, so that valid_out=0, ready_out=1 and pressure_out=0.
REQ-028 Memory contents SHALL NOT be reset; data_out is don't-care while valid_out=0.
REQ-029 Reset asserted mid-operation SHALL discard all stored flits immediately; the first post-reset push SHALL land in entry 0.
REQ-030 Deassertion of rst SHALL be usable synchronously to ib_clk; no push or pop occurs on an edge where rst=1.

Verification
REQ-031 Reset: assert rst asynchronously between edges -> valid_out=0, ready_out=1, pressure_out=0, overflow_err=0 before the next edge.
REQ-032 Fill and drain: push 8 flits 0x01..0x08 with rc_ready=0 -> pressure_out steps 1..8 and ready_out=0 after the 8th push; then rc_ready=1 -> data_out reads 0x01..0x08 in order, and valid_out=0 after 8 pops.
REQ-033 Overflow: when full, drive valid_in=1 with 0xFF -> flit dropped, count=8, overflow_err=1 and sticky; drain -> 0xFF never appears.
REQ-034 Simultaneous push and pop: with count=4, drive valid_in=1 and rc_ready=1 for 10 cycles -> pressure_out stays 4, pointers wrap past 7->0, and data order is preserved.
REQ-035 Full plus pop: with count=8, drive valid_in=1 and rc_ready=1 -> only the pop occurs, count=7; next cycle ready_out=1 and the push is accepted.
REQ-036 Mid-operation reset: with count=5, pulse rst -> count=0; push 0xA5 -> data_out=0xA5 one cycle later, and pressure_out=1.
